// File: rtl/counter_stream_checker.sv
// Consumer end of a free-running counter stream: checks each accepted sample is the previous + 1,
// counts samples and mismatches, and reports a sticky done/pass/fail verdict with a watchdog.
module counter_stream_checker #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PASS_COUNT     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned ERR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [31:0]           sample_count,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  typedef enum logic [1:0] {StIdle, StSync, StCheck, StDone} state_e;

  localparam logic [31:0]          PassCount = 32'(PASS_COUNT);
  localparam logic [31:0]          WdogLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] ErrMax    = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [31:0]           wdog_q, wdog_d;
  logic [31:0]           sample_count_q, sample_count_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] first_err_q, first_err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic                  accept;

  assign in_ready = (state_q == StSync) || (state_q == StCheck);
  assign busy     = in_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    wdog_d         = wdog_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    first_err_d    = first_err_q;
    done_d         = done_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    timeout_d      = timeout_q;

    if (start_i) begin
      // Start (or restart) clears the run; an accept on this cycle is discarded.
      state_d        = StSync;
      expected_d     = '0;
      wdog_d         = '0;
      sample_count_d = '0;
      err_count_d    = '0;
      first_err_d    = '0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
      fail_d         = 1'b0;
      timeout_d      = 1'b0;
    end else begin
      unique case (state_q)
        StSync, StCheck: begin
          if (accept) begin
            expected_d     = in_data + DATA_WIDTH'(1);
            sample_count_d = sample_count_q + 32'd1;
            if (state_q == StSync) begin
              state_d = StCheck;
            end else if (in_data != expected_q) begin
              if (err_count_q != ErrMax) err_count_d = err_count_q + ERR_WIDTH'(1);
              // err_count never returns to zero within a run, so zero marks the first miss.
              if (err_count_q == '0) first_err_d = in_data;
            end
          end
          if (accept && (state_q == StCheck) && (sample_count_d == PassCount)) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            fail_d  = (err_count_d != '0);
          end else if (wdog_q == WdogLast) begin
            state_d   = StDone;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            fail_d    = 1'b1;
            pass_d    = 1'b0;
          end else begin
            wdog_d = wdog_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      expected_q     <= '0;
      wdog_q         <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      first_err_q    <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      wdog_q         <= wdog_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      first_err_q    <= first_err_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
    end
  end

  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign sample_count   = sample_count_q;
  assign first_err_data = first_err_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Randomized bench for counter_stream_checker: a list-of-accepted-samples model derives the
// expected verdict and counters, compared against every output after each clock edge.
module tb_counter_stream_checker;

  localparam int unsigned Dw   = 32;
  localparam int unsigned Pass = 100;
  localparam int unsigned Tmo  = 1000;
  localparam int unsigned Ew   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          in_valid;
  logic [Dw-1:0] in_data;
  logic          in_ready, busy, done, pass, fail, timeout;
  logic [Ew-1:0] err_count;
  logic [31:0]   sample_count;
  logic [Dw-1:0] first_err_data;

  counter_stream_checker #(
    .DATA_WIDTH    (Dw),
    .PASS_COUNT    (Pass),
    .TIMEOUT_CYCLES(Tmo),
    .ERR_WIDTH     (Ew)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .err_count     (err_count),
    .sample_count  (sample_count),
    .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is the list of samples accepted since start.
  logic [Dw-1:0] acc[$];
  logic [Dw-1:0] stim[$];
  bit            m_active, m_done, m_to, last_acc;
  longint        n_cyc = 0;
  longint        t_start = 0;

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_to     = 0;
    acc.delete();
  endtask

  task automatic compare_all();
    int            e  = 0;
    logic [Dw-1:0] fe = '0;
    for (int i = 1; i < acc.size(); i++) begin
      if (acc[i] != acc[i-1] + 32'd1) begin
        if (e == 0) fe = acc[i];
        e++;
      end
    end
    check("in_ready", in_ready, m_active);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("timeout", timeout, m_to);
    check("pass", pass, m_done && !m_to && e == 0);
    check("fail", fail, m_done && (m_to || e != 0));
    check("err_count", err_count, (e > 65535) ? 65535 : e);
    check("sample_count", sample_count, acc.size());
    check("first_err_data", first_err_data, fe);
  endtask

  task automatic cyc(input logic s, input logic v, input logic [Dw-1:0] d);
    start_i  = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    n_cyc++;
    last_acc = 0;
    if (!rst_n) begin
      model_reset();
    end else if (s) begin
      model_reset();
      m_active = 1;
      t_start  = n_cyc;
    end else if (m_active) begin
      if (v) begin
        acc.push_back(d);
        last_acc = 1;
      end
      if (acc.size() == Pass) begin
        m_active = 0;
        m_done   = 1;
      end else if (n_cyc - t_start == Tmo) begin
        m_active = 0;
        m_done   = 1;
        m_to     = 1;
      end
    end
    #1 compare_all();
  endtask

  // Start a run and feed stim[] with random gaps until stop_at accepts or a verdict.
  task automatic run(input int gap_pct, input int stop_at);
    int idx = 0;
    bit v;
    cyc(1'b1, 1'b1, $urandom);
    for (int c = 0; c < 3000 && !m_done && acc.size() < stop_at; c++) begin
      v = (idx < stim.size()) && ($urandom_range(99) >= gap_pct);
      cyc(1'b0, v, v ? stim[idx] : $urandom);
      if (last_acc) idx++;
    end
    if (!m_done && acc.size() < stop_at) check("run_budget", 0, 1);
  endtask

  task automatic fill(input logic [Dw-1:0] base, input int skip_at, input int bad_pct);
    logic [Dw-1:0] v = base;
    stim.delete();
    for (int i = 0; i < Pass; i++) begin
      if (i == skip_at) v = v + 32'd1;
      stim.push_back(($urandom_range(99) < bad_pct) ? $urandom : v);
      v = v + 32'd1;
    end
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, $urandom);
  endtask

  initial begin
    int k;
    rst_n = 0;
    model_reset();
    start_i = 0; in_valid = 0; in_data = '0;
    #1 compare_all();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom);
    rst_n = 1;
    junk(5);

    // 1: clean stream, valid held high
    fill(32'd0, -1, 0);
    run(0, Pass);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_samples", sample_count, 100);
    check("t1_err", err_count, 0);
    junk(3);

    // 2: single skip of 41 yields exactly one error
    fill(32'd0, 41, 0);
    run(0, Pass);
    check("t2_err", err_count, 1);
    check("t2_first", first_err_data, 42);
    check("t2_fail", fail, 1);
    check("t2_pass", pass, 0);

    // 3: wrap across all-ones
    fill(32'hFFFF_FFFE, -1, 0);
    run(20, Pass);
    check("t3_pass", pass, 1);
    check("t3_err", err_count, 0);

    // 4: no samples at all -> watchdog
    cyc(1'b1, 1'b0, '0);
    k = 0;
    for (int c = 0; c < 1100 && !done; c++) begin
      cyc(1'b0, 1'b0, $urandom);
      k++;
    end
    check("t4_latency", k, Tmo);
    check("t4_timeout", timeout, 1);
    check("t4_fail", fail, 1);
    check("t4_samples", sample_count, 0);
    check("t4_busy", busy, 0);
    junk(4);

    // 5: random gaps, junk in IDLE/DONE ignored
    fill($urandom, -1, 0);
    run(50, Pass);
    junk(10);
    check("t5_pass", pass, 1);
    check("t5_samples", sample_count, 100);

    // 6: reset mid-CHECK, then a fresh run
    fill($urandom, -1, 0);
    run(10, 50);
    check("t6_mid_samples", sample_count, 50);
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom);
    rst_n = 1;
    junk(2);
    fill($urandom, -1, 0);
    run(10, Pass);
    check("t6_pass", pass, 1);
    check("t6_samples", sample_count, 100);

    // 7: restart mid-run, then random corruptions
    fill($urandom, -1, 0);
    run(0, 20);
    for (int r = 0; r < 4; r++) begin
      fill($urandom, -1, 5);
      run(30, Pass);
      junk(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
- Consumer end of the free-running counter stream used by the comprehensive test benches.
- Accepts counter samples over a valid/ready handshake and checks that each sample equals the previous accepted sample + 1, modulo 2^DATA_WIDTH.
- Counts accepted samples and mismatches, and enforces a cycle-timeout watchdog.
- Reports a sticky done/pass/fail verdict that benches and the self-test harness poll.

Parameters:
- DATA_WIDTH, 32, width of counter samples.
- PASS_COUNT, 100, accepted samples required for a verdict; must be ≥ 2.
- TIMEOUT_CYCLES, 1000, cycles after start before timeout verdict; must be > PASS_COUNT.
- ERR_WIDTH, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; begins or restarts a check run.
- in_valid  in  1  sample valid.
- in_data  in  DATA_WIDTH  counter sample.
- in_ready  out  1  checker accepts a sample this cycle.
- busy  out  1  run in progress (SYNC or CHECK).
- done  out  1  verdict available; sticky until next start or reset.
- pass  out  1  run completed with zero mismatches.
- fail  out  1  run completed with mismatches, or timed out.
- timeout  out  1  run ended by watchdog.
- err_count  out  ERR_WIDTH  mismatches this run; saturates at all-ones.
- sample_count  out  32  samples accepted this run.
- first_err_data  out  DATA_WIDTH  in_data of the first mismatching sample; 0 if none.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - State = IDLE.
  - All outputs and internal registers 0: expected value, watchdog, counters.
- Accept = in_valid & in_ready.
- in_ready = 1 only in SYNC and CHECK. Decoded from the registered state; no combinational path from in_valid.
- FSM:
  - IDLE:
    - start_i → SYNC.
    - On the same edge, clear done/pass/fail/timeout, err_count, sample_count, first_err_data and watchdog.
  - SYNC:
    - First accept seeds the check; it is never a mismatch.
    - expected ← in_data + 1 (wraps), sample_count ← 1, → CHECK.
  - CHECK, on each accept:
    - sample_count +1.
    - If in_data ≠ expected: err_count +1 (saturating). If this is the first mismatch of the run, first_err_data ← in_data.
    - Always resync: expected ← in_data + 1, whether or not the sample mismatched. A single skip therefore yields exactly one error.
    - Verdict: when the accept brings sample_count to PASS_COUNT, → DONE.
      - pass = (updated err_count == 0); fail = ~pass.
      - done rises the cycle after the final accept.
  - DONE:
    - in_ready = 0; all outputs held.
    - start_i → SYNC with the same clearing as from IDLE.
- Watchdog:
  - Counts every cycle in SYNC/CHECK, starting at 0 on the cycle after start.
  - On reaching TIMEOUT_CYCLES−1 without a verdict, → DONE with timeout = 1, fail = 1, pass = 0.
  - Counters keep their partial values.
- Simultaneous events:
  - Final accept and watchdog expiry on the same cycle: the accept wins. Sample counted, normal verdict, timeout = 0.
  - start_i during SYNC/CHECK: restart. Counters cleared, → SYNC; any accept on that cycle is discarded.
  - start_i and reset: reset wins.
- Wrap-around: expected is computed modulo 2^DATA_WIDTH, so all-ones followed by 0 is correct.
- busy = state ∈ {SYNC, CHECK}.
- Reset mid-run: immediate return to IDLE with all outputs 0; the next start behaves as after power-up.

Test Plan:
1. start, then stream 0,1,…,99 with in_valid held high (PASS_COUNT = 100) → done = 1 and pass = 1 one cycle after the 100th accept; err_count = 0; sample_count = 100; timeout = 0.
2. Stream 0..40, 42, 43, …, to 100 samples → err_count = 1, first_err_data = 42, fail = 1, pass = 0; no further errors after the resync.
3. Seed 0xFFFFFFFE, then 0xFFFFFFFF, 0, 1, … → pass = 1, err_count = 0 across the wrap.
4. start with in_valid never asserted → done = timeout = fail = 1 exactly TIMEOUT_CYCLES cycles after start; sample_count = 0; busy = 0 afterwards.
5. Random in_valid gaps on a correct stream; in_valid = 1 with junk data while in IDLE/DONE → in_ready = 0 in IDLE/DONE and junk ignored; pass = 1, sample_count = 100.
6. rst_n low for 3 cycles mid-CHECK at sample 50, then start and a fresh stream → all outputs 0 during reset; second run passes with sample_count = 100.
